// File: rtl/uart_pkg.sv
// Shared types and constants for the word-wide UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  localparam logic        UART_IDLE_LEVEL = 1'b1;
  localparam int unsigned BITS_PER_BYTE   = 8;
  localparam int unsigned BYTES_PER_WORD  = 4;
  localparam int unsigned WORD_W          = 32;
  localparam int unsigned BAUD_W          = 16;

endpackage

// File: rtl/word_fifo.sv
// Synchronous word FIFO; pointers wrap modulo DEPTH, count disambiguates full/empty.
module word_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WORD_W-1:0]        din,
  output logic [WORD_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/uart_word_tx.sv
// Buffers 32-bit store words and sends each as four 8N1 frames, byte 0 first.
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DEPTH        = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [WORD_W-1:0]  data,
  output logic               full,
  output logic               empty,
  output logic               busy,
  output logic               overflow,
  output logic               word_done,
  output logic               tx_serial
);

  localparam int unsigned CNT_W      = $clog2(DEPTH) + 1;
  localparam int unsigned BIT_IDX_W  = $clog2(BITS_PER_BYTE);
  localparam int unsigned BYTE_IDX_W = $clog2(BYTES_PER_WORD);

  tx_state_e              state_q, state_d;
  logic [BAUD_W-1:0]      baud_q, baud_d;
  logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [BYTE_IDX_W-1:0]  byte_idx_q, byte_idx_d;
  logic [WORD_W-1:0]      shreg_q, shreg_d;
  logic                   tx_q, tx_d;
  logic                   done_pend_q, done_pend_d;
  logic                   word_done_q, word_done_d;
  logic                   overflow_q, overflow_d;

  logic                   pop;
  logic                   push;
  logic                   baud_last;
  logic [WORD_W-1:0]      fifo_dout;
  logic [CNT_W-1:0]       fifo_count;
  logic [BITS_PER_BYTE-1:0] cur_byte;
  logic                   unused_count;

  assign pop          = (state_q == IDLE) & ~empty;
  assign push         = we & (~full | pop);
  assign baud_last    = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign cur_byte     = shreg_q[BITS_PER_BYTE-1:0];
  assign unused_count = ^fifo_count;

  word_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (data),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // tx_d is the line level for the current state; the register delays it one cycle.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_idx_d   = bit_idx_q;
    byte_idx_d  = byte_idx_q;
    shreg_d     = shreg_q;
    tx_d        = UART_IDLE_LEVEL;
    done_pend_d = 1'b0;
    word_done_d = done_pend_q;
    overflow_d  = overflow_q | (we & ~push);

    case (state_q)
      IDLE: begin
        if (pop) begin
          shreg_d    = fifo_dout;
          byte_idx_d = '0;
          baud_d     = '0;
          state_d    = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (baud_last) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        tx_d = cur_byte[bit_idx_q];
        if (baud_last) begin
          baud_d = '0;
          if (bit_idx_q == BIT_IDX_W'(BITS_PER_BYTE - 1)) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        tx_d = UART_IDLE_LEVEL;
        if (baud_last) begin
          baud_d = '0;
          if (byte_idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1)) begin
            done_pend_d = 1'b1;
            state_d     = IDLE;
          end else begin
            byte_idx_d = byte_idx_q + BYTE_IDX_W'(1);
            shreg_d    = shreg_q >> BITS_PER_BYTE;
            state_d    = START;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_idx_q   <= '0;
      byte_idx_q  <= '0;
      shreg_q     <= '0;
      tx_q        <= UART_IDLE_LEVEL;
      done_pend_q <= 1'b0;
      word_done_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_idx_q   <= bit_idx_d;
      byte_idx_q  <= byte_idx_d;
      shreg_q     <= shreg_d;
      tx_q        <= tx_d;
      done_pend_q <= done_pend_d;
      word_done_q <= word_done_d;
      overflow_q  <= overflow_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign overflow  = overflow_q;
  assign word_done = word_done_q;
  assign tx_serial = tx_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx: timing model, line decoder and hand-computed checks.
module tb_uart_word_tx;

  localparam int C  = 4;
  localparam int D  = 4;
  localparam int WT = 40 * C;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] data;
  logic        full, empty, busy, overflow, word_done, tx_serial;

  always #5 clk = ~clk;

  uart_word_tx #(
    .CLKS_PER_BIT (C),
    .DEPTH        (D)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .data      (data),
    .full      (full),
    .empty     (empty),
    .busy      (busy),
    .overflow  (overflow),
    .word_done (word_done),
    .tx_serial (tx_serial)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: queue of accepted words plus the age (edges since pop) of the word on the line.
  logic [31:0] mq[$];
  logic [31:0] m_word;
  logic        m_active, m_ovf, m_done, m_en;
  int          m_age;

  function automatic logic exp_tx();
    int b, fb, by;
    if (m_active && m_age >= 1 && m_age <= WT) begin
      b  = (m_age - 1) / C;
      fb = b % 10;
      by = b / 10;
      if (fb == 0) return 1'b0;
      if (fb == 9) return 1'b1;
      return m_word[by*8 + fb - 1];
    end
    return 1'b1;
  endfunction

  initial begin
    bit idle, popn, acc;
    m_active = 0; m_ovf = 0; m_done = 0; m_en = 0; m_age = 0; m_word = '0;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        mq.delete();
        m_active = 0; m_age = 0; m_ovf = 0; m_done = 0; m_en = 1;
      end else begin
        idle   = !m_active || m_age >= WT;
        popn   = idle && mq.size() > 0;
        m_done = m_active && m_age == WT;
        acc    = we && (mq.size() < D || popn);
        if (popn) begin
          m_word = mq.pop_front();
          m_active = 1;
          m_age = 0;
        end else if (m_active && m_age < WT + 1) begin
          m_age++;
        end
        if (acc) mq.push_back(data);
        if (we && !acc) m_ovf = 1;
      end
      @(negedge clk);
      if (m_en) begin
        chk("tx_serial", 32'(tx_serial), 32'(exp_tx()));
        chk("busy", 32'(busy), 32'(m_active && m_age <= WT - 1));
        chk("full", 32'(full), 32'(mq.size() == D));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("word_done", 32'(word_done), 32'(m_done));
      end
    end
  end

  // Independent line receiver: mid-bit sampling of each 8N1 frame.
  logic [7:0] rx_bytes[$];
  logic [7:0] rx_sh;
  logic       rx_act;
  int         rx_off;

  initial begin
    rx_act = 0; rx_off = 0; rx_sh = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        rx_act = 0;
      end else if (!rx_act) begin
        if (tx_serial === 1'b0) begin
          rx_act = 1;
          rx_off = 0;
        end
      end else begin
        rx_off++;
        if (rx_off % C == 1 && rx_off >= C + 1 && rx_off <= 8*C + 1)
          rx_sh[(rx_off - 1)/C - 1] = tx_serial;
        if (rx_off == 9*C + 1) begin
          chk("rx_stop_bit", 32'(tx_serial), 32'd1);
          rx_bytes.push_back(rx_sh);
          rx_act = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; we = 0;
    tick(); tick();
    reset = 0;
    rx_bytes.delete();
  endtask

  task automatic write(input logic [31:0] d);
    we = 1; data = d;
    tick();
    we = 0;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int t = 0;
    while (rx_bytes.size() < n && t < budget) begin
      tick();
      t++;
    end
    chk("rx_byte_count", 32'(rx_bytes.size()), 32'(n));
  endtask

  task automatic chk_words(input string name, input logic [31:0] exp_w[$]);
    logic [31:0] w;
    for (int k = 0; k < exp_w.size(); k++) begin
      if (4*k + 3 < rx_bytes.size())
        w = {rx_bytes[4*k+3], rx_bytes[4*k+2], rx_bytes[4*k+1], rx_bytes[4*k]};
      else
        w = 'x;
      chk(name, w, exp_w[k]);
    end
  endtask

  logic        line_s[$];
  logic [7:0]  b1_exp [4];
  logic [31:0] exp_w[$];

  initial begin
    int n, busy_cnt, done_at, done_cnt, base, i, guard;
    logic [7:0] byt;
    reset = 1; we = 0; data = '0;
    b1_exp[0] = 8'h11; b1_exp[1] = 8'h22; b1_exp[2] = 8'h33; b1_exp[3] = 8'h44;

    // Reset values
    do_reset();
    @(negedge clk);
    chk("rst_tx", 32'(tx_serial), 32'd1);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Single word: frame contents, busy span, word_done edge
    write(32'h44332211);
    n = cyc;
    busy_cnt = 0; done_at = -1; done_cnt = 0;
    line_s.delete();
    repeat (170) begin
      @(negedge clk);
      line_s.push_back(tx_serial);
      if (busy) busy_cnt++;
      if (word_done) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end
    end
    for (int j = 0; j < 4; j++) begin
      base = 2 + 40*j;
      chk("w1_start_bit", 32'(line_s[base]), 32'd0);
      for (int b = 0; b < 8; b++) byt[b] = line_s[base + 4*(1 + b)];
      chk("w1_byte", 32'(byt), 32'(b1_exp[j]));
      chk("w1_stop_bit", 32'(line_s[base + 36]), 32'd1);
    end
    chk("w1_first_low", 32'(line_s[1]), 32'd1);
    chk("w1_busy_cycles", 32'(busy_cnt), 32'd160);
    chk("w1_done_edge", 32'(done_at), 32'(n + 162));
    chk("w1_done_count", 32'(done_cnt), 32'd1);

    // Back-to-back stores 1..5
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      we = 1; data = 32'(k);
      tick();
    end
    we = 0;
    @(negedge clk);
    chk("b2b_full", 32'(full), 32'd1);
    chk("b2b_overflow", 32'(overflow), 32'd0);
    wait_bytes(20, 1200);
    exp_w = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    chk_words("b2b_word", exp_w);

    // Overflow: sixth store dropped
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      we = 1; data = 32'(k);
      tick();
    end
    we = 0;
    @(negedge clk);
    chk("ovf_set", 32'(overflow), 32'd1);
    wait_bytes(20, 1200);
    repeat (200) tick();
    chk("ovf_rx_total", 32'(rx_bytes.size()), 32'd20);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk_words("ovf_word", exp_w);

    // Full with simultaneous pop
    do_reset();
    write(32'hA0A0A0A0);
    n = cyc;
    write(32'hB1B1B1B1); write(32'hC2C2C2C2); write(32'hD3D3D3D3); write(32'hE4E4E4E4);
    @(negedge clk);
    chk("fp_full_before", 32'(full), 32'd1);
    while (cyc < n + 161) tick();
    we = 1; data = 32'hF5F5F5F5;
    tick();
    we = 0;
    @(negedge clk);
    chk("fp_edge", 32'(cyc), 32'(n + 162));
    chk("fp_full_after", 32'(full), 32'd1);
    chk("fp_no_overflow", 32'(overflow), 32'd0);
    chk("fp_word_done", 32'(word_done), 32'd1);
    wait_bytes(24, 1200);
    exp_w = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3, 32'hE4E4E4E4, 32'hF5F5F5F5};
    chk_words("fp_word", exp_w);

    // Reset mid-frame during DATA of byte 2 with two words queued
    do_reset();
    write(32'h0F1E2D3C);
    n = cyc;
    write(32'h11111111); write(32'h22222222);
    while (cyc < n + 1 + 92) tick();
    reset = 1;
    tick();
    reset = 0;
    @(negedge clk);
    chk("mr_tx", 32'(tx_serial), 32'd1);
    chk("mr_empty", 32'(empty), 32'd1);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_overflow", 32'(overflow), 32'd0);
    chk("mr_rx_before", 32'(rx_bytes.size()), 32'd2);
    repeat (400) tick();
    chk("mr_rx_after", 32'(rx_bytes.size()), 32'd2);

    // Pointer wrap: 3*DEPTH random words
    do_reset();
    exp_w.delete();
    i = 0; guard = 0;
    while (i < 3*D && guard < 5000) begin
      if (!full) begin
        we = 1; data = $urandom;
        exp_w.push_back(data);
        i++;
      end else begin
        we = 0;
      end
      tick();
      guard++;
    end
    we = 0;
    chk("wrap_pushed", 32'(i), 32'(3*D));
    wait_bytes(4*3*D, 3000);
    chk_words("wrap_word", exp_w);
    chk("wrap_overflow", 32'(overflow), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
